keypad_scanner: RTL and testbench

//  Input-side counterpart of the multiplexed 4-digit LED driver: strobes the 4 columns of a 4x4

---
 rtl/keypad_scanner_pkg.sv | 41 ++++
 rtl/keypad_scanner_debounce.sv | 141 ++++++++++++++
 rtl/keypad_scanner.sv | 102 ++++++++++
 tb/tb_keypad_scanner.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: matrix geometry, frame-result and debounce-state
// encodings, and small helpers for collapsing per-column row samples into a frame result.
package keypad_scanner_pkg;

  localparam int unsigned N_ROWS = 4;
  localparam int unsigned N_COLS = 4;
  localparam int unsigned KEY_W  = 4;

  typedef enum logic [1:0] {
    ResNone   = 2'd0,
    ResSingle = 2'd1,
    ResMulti  = 2'd2
  } frame_res_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPressDb = 2'd1,
    StPressed = 2'd2,
    StRelDb   = 2'd3
  } db_state_e;

  // Running key count for a frame, saturating at 2 (anything above one key is MULTI).
  function automatic logic [1:0] add_sat(input logic [1:0] acc, input logic [N_ROWS-1:0] rows);
    int unsigned n;
    n = int'(acc);
    for (int i = 0; i < N_ROWS; i++) begin
      n += int'(rows[i]);
    end
    return (n > 2) ? 2'd2 : 2'(n);
  endfunction

  function automatic logic [1:0] first_row(input logic [N_ROWS-1:0] rows);
    logic [1:0] idx;
    idx = '0;
    for (int i = N_ROWS - 1; i >= 0; i--) begin
      if (rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_debounce.sv
// Per-frame press/release debouncer with a single-entry valid/ack event register.
// Evaluated once per frame end; emitted events land one cycle after the frame-end sample.
module keypad_scanner_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_frame_end,
  input  frame_res_e       i_res,
  input  logic [KEY_W-1:0] i_code,
  input  logic             i_key_ack,
  output logic [KEY_W-1:0] o_key_code,
  output logic             o_key_valid,
  output logic             o_key_down,
  output logic             o_overrun
);

  localparam int unsigned    DCNT_W      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DCNT_W-1:0] DCNT_MAX = {DCNT_W{1'b1}};
  localparam logic [DCNT_W-1:0] DCNT_HIT = DCNT_W'(DEBOUNCE_SCANS);
  localparam logic [DCNT_W-1:0] DCNT_ONE = DCNT_W'(1);
  localparam bit             SINGLE_SCAN = (DEBOUNCE_SCANS == 1);

  db_state_e         r_state;
  logic [DCNT_W-1:0] r_dcnt;
  logic [KEY_W-1:0]  r_cand;
  logic [KEY_W-1:0]  r_key_code;
  logic              r_key_valid;
  logic              r_key_down;
  logic              r_overrun;

  logic [DCNT_W-1:0] w_dcnt_inc;
  logic              w_hit;
  logic              w_match;
  logic              w_emit;

  assign w_dcnt_inc = (r_dcnt == DCNT_MAX) ? r_dcnt : r_dcnt + DCNT_ONE;
  assign w_hit      = (w_dcnt_inc == DCNT_HIT);
  assign w_match    = (i_res == ResSingle) && (i_code == r_cand);
  // Both emitting paths only fire on SINGLE(i_code), so i_code is the code to deliver.
  assign w_emit     = i_frame_end &&
                      (((r_state == StIdle) && (i_res == ResSingle) && SINGLE_SCAN) ||
                       ((r_state == StPressDb) && w_match && w_hit));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_dcnt      <= '0;
      r_cand      <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_emit) begin
        if (!r_key_valid || i_key_ack) begin
          r_key_code  <= i_code;
          r_key_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_key_valid && i_key_ack) begin
        r_key_valid <= 1'b0;
      end

      if (i_frame_end) begin
        unique case (r_state)
          StIdle: begin
            if (i_res == ResSingle) begin
              r_cand <= i_code;
              if (SINGLE_SCAN) begin
                r_state    <= StPressed;
                r_key_down <= 1'b1;
                r_dcnt     <= '0;
              end else begin
                r_state <= StPressDb;
                r_dcnt  <= DCNT_ONE;
              end
            end
          end
          StPressDb: begin
            if (w_match) begin
              if (w_hit) begin
                r_state    <= StPressed;
                r_key_down <= 1'b1;
                r_dcnt     <= '0;
              end else begin
                r_dcnt <= w_dcnt_inc;
              end
            end else if (i_res == ResSingle) begin
              r_cand <= i_code;
              r_dcnt <= DCNT_ONE;
            end else begin
              r_state <= StIdle;
              r_dcnt  <= '0;
            end
          end
          StPressed: begin
            if (i_res == ResNone) begin
              if (SINGLE_SCAN) begin
                r_state    <= StIdle;
                r_key_down <= 1'b0;
                r_dcnt     <= '0;
              end else begin
                r_state <= StRelDb;
                r_dcnt  <= DCNT_ONE;
              end
            end
          end
          StRelDb: begin
            // MULTI counts as still held so a ghosted frame cannot release the key.
            if (i_res == ResNone) begin
              if (w_hit) begin
                r_state    <= StIdle;
                r_key_down <= 1'b0;
                r_dcnt     <= '0;
              end else begin
                r_dcnt <= w_dcnt_inc;
              end
            end else begin
              r_state <= StPressed;
              r_dcnt  <= '0;
            end
          end
          default: begin
            r_state <= StIdle;
            r_dcnt  <= '0;
          end
        endcase
      end
    end
  end

  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_key_down  = r_key_down;
  assign o_overrun   = r_overrun;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one active-low column per slot, samples synchronised rows at
// the end of each slot, folds four slots into a frame result and hands it to the debouncer.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 16384,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [N_COLS-1:0] o_col_n,
  input  logic [N_ROWS-1:0] i_row_n,
  output logic [KEY_W-1:0]  o_key_code,
  output logic              o_key_valid,
  input  logic              i_key_ack,
  output logic              o_key_down,
  output logic              o_overrun
);

  localparam int unsigned        SLOT_W    = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0]  SLOT_ONE  = SLOT_W'(1);

  logic [N_ROWS-1:0] r_row_meta;
  logic [N_ROWS-1:0] r_row_sync;
  logic [SLOT_W-1:0] r_slot;
  logic [1:0]        r_col;
  logic [N_COLS-1:0] r_col_n;
  logic [1:0]        r_acc_cnt;
  logic [KEY_W-1:0]  r_acc_code;

  logic              w_sample;
  logic              w_frame_end;
  logic [N_ROWS-1:0] w_rows_low;
  logic [1:0]        w_cnt;
  logic [KEY_W-1:0]  w_code;
  frame_res_e        w_res;

  assign w_sample    = (r_slot == SLOT_LAST);
  assign w_frame_end = w_sample && (r_col == 2'd3);
  assign w_rows_low  = ~r_row_sync;
  assign w_cnt       = add_sat(r_acc_cnt, w_rows_low);
  // The code only matters when the frame holds exactly one key; it comes from whichever
  // slot saw it first.
  assign w_code      = (r_acc_cnt != 2'd0) ? r_acc_code : {first_row(w_rows_low), r_col};

  always_comb begin
    w_res = ResMulti;
    if (w_cnt == 2'd0) begin
      w_res = ResNone;
    end else if (w_cnt == 2'd1) begin
      w_res = ResSingle;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row_meta <= '1;
      r_row_sync <= '1;
      r_slot     <= '0;
      r_col      <= '0;
      r_col_n    <= 4'b1110;
      r_acc_cnt  <= '0;
      r_acc_code <= '0;
    end else begin
      r_row_meta <= i_row_n;
      r_row_sync <= r_row_meta;
      if (w_sample) begin
        r_slot  <= '0;
        r_col   <= r_col + 2'd1;
        r_col_n <= {r_col_n[N_COLS-2:0], r_col_n[N_COLS-1]};
        if (w_frame_end) begin
          r_acc_cnt  <= '0;
          r_acc_code <= '0;
        end else begin
          r_acc_cnt  <= w_cnt;
          r_acc_code <= w_code;
        end
      end else begin
        r_slot <= r_slot + SLOT_ONE;
      end
    end
  end

  assign o_col_n = r_col_n;

  keypad_scanner_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_frame_end (w_frame_end),
    .i_res       (w_res),
    .i_code      (w_code),
    .i_key_ack   (i_key_ack),
    .o_key_code  (o_key_code),
    .o_key_valid (o_key_valid),
    .o_key_down  (o_key_down),
    .o_overrun   (o_overrun)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Frame-level bench for keypad_scanner: an ideal key matrix driven from a held-key mask, checked
// against a run-length press/release model with a one-deep event slot.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DB       = 3;
  localparam int unsigned FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       ack;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       overrun;
  logic [15:0] held;

  int total;
  int bad;

  // Reference model state.
  bit m_valid;
  bit m_down;
  bit m_over;
  int m_code;
  int m_run;
  int m_last;
  int m_rel;

  always #5 clk = ~clk;

  // Ideal matrix: row r is pulled low when a held key in row r sits on the strobed column.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++) begin
      row_n[r] = ~|(held[r*4 +: 4] & ~col_n);
    end
  end

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .o_col_n     (col_n),
    .i_row_n     (row_n),
    .o_key_code  (key_code),
    .o_key_valid (key_valid),
    .i_key_ack   (ack),
    .o_key_down  (key_down),
    .o_overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_down  = 0;
    m_over  = 0;
    m_code  = 0;
    m_run   = 0;
    m_last  = 0;
    m_rel   = 0;
  endtask

  // One frame of the model: what the keypad showed decides press/release progress.
  task automatic model_frame(input logic [15:0] mask, input bit ack_end);
    int  n;
    int  code;
    bit  emit;
    n    = $countones(mask);
    code = 0;
    for (int k = 0; k < 16; k++) if (mask[k]) code = k;
    emit = 0;
    if (!m_down) begin
      if (n == 1) begin
        if (m_run > 0 && code == m_last) m_run++;
        else begin
          m_run  = 1;
          m_last = code;
        end
        if (m_run == DB) begin
          m_down = 1;
          m_rel  = 0;
          emit   = 1;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (n == 0) m_rel++;
      else m_rel = 0;
      if (m_rel == DB) begin
        m_down = 0;
        m_run  = 0;
        m_rel  = 0;
      end
    end
    if (emit) begin
      if (!m_valid || ack_end) begin
        m_code  = code;
        m_valid = 1;
      end else begin
        m_over = 1;
      end
    end else if (ack_end && m_valid) begin
      m_valid = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, key_valid, m_valid);
    check({tag, "_down"}, key_down, m_down);
    check({tag, "_overrun"}, overrun, m_over);
    if (m_valid) check({tag, "_code"}, key_code, m_code);
  endtask

  // Entered #1 after a clock edge; leaves #1 after the reset edge, which is frame-start aligned.
  task automatic do_reset();
    rst = 1'b1;
    ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("rst_col_n", col_n, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_down", key_down, 0);
    check("rst_overrun", overrun, 0);
    check("rst_code", key_code, 0);
  endtask

  // ack_mode: 0 none, 1 pulse mid-frame, 2 pulse on the frame-end edge.
  task automatic run_frame(input logic [15:0] mask, input int ack_mode, input string tag);
    logic [3:0] exp_col;
    held = mask;
    for (int i = 1; i <= FRAME; i++) begin
      if ((ack_mode == 1 && i == 8) || (ack_mode == 2 && i == FRAME)) ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
      exp_col = ~(4'b0001 << ((i / SCAN_DIV) % 4));
      check({tag, "_col_n"}, col_n, exp_col);
      if (ack_mode == 1 && i == 8) begin
        m_valid = 0;
        check({tag, "_ackmid_valid"}, key_valid, 0);
      end
    end
    model_frame(mask, ack_mode == 2);
    check_outputs(tag);
  endtask

  task automatic run_frames(input logic [15:0] mask, input int n, input string tag);
    for (int f = 0; f < n; f++) run_frame(mask, 0, tag);
  endtask

  initial begin
    int cur;
    int sel;
    logic [15:0] mask;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ack   = 1'b0;
    held  = '0;
    model_reset();
    #1;

    // 1: idle keypad
    do_reset();
    run_frames(16'h0000, 2, "idle");

    // 2: key 6 (row1, col2) held, event after the 3rd frame, ack clears it
    run_frames(16'h0040, 2, "k6_pre");
    check("k6_not_yet", key_valid, 0);
    run_frame(16'h0040, 0, "k6_emit");
    check("k6_valid", key_valid, 1);
    check("k6_code", key_code, 6);
    check("k6_down", key_down, 1);
    run_frame(16'h0040, 0, "k6_hold");
    run_frame(16'h0040, 1, "k6_ack");
    run_frames(16'h0000, 3, "k6_rel");
    check("k6_released", key_down, 0);

    // 3: broken hold restarts debounce
    run_frames(16'h0040, 2, "brk_a");
    run_frame(16'h0000, 0, "brk_gap");
    run_frames(16'h0040, 2, "brk_b");
    check("brk_not_yet", key_valid, 0);
    run_frame(16'h0040, 0, "brk_emit");
    check("brk_valid", key_valid, 1);
    run_frame(16'h0040, 1, "brk_ack");
    run_frames(16'h0000, 3, "brk_rel");

    // 4: unacked event blocks the next one, then ack on the emit edge replaces it
    run_frames(16'h0001, 3, "k0");
    run_frames(16'h0000, 3, "k0_rel");
    run_frames(16'h8000, 3, "k15");
    check("ovr_code", key_code, 0);
    check("ovr_flag", overrun, 1);
    run_frames(16'h0000, 3, "k15_rel");
    run_frames(16'h0200, 2, "k9");
    run_frame(16'h0200, 2, "k9_ackemit");
    check("k9_valid", key_valid, 1);
    check("k9_code", key_code, 9);
    run_frames(16'h0000, 3, "k9_rel");
    run_frame(16'h0000, 1, "k9_ack");

    // 5: two keys together never press; a second key while pressed is ignored
    run_frames(16'h0420, 4, "multi");
    check("multi_none", key_valid, 0);
    run_frames(16'h0020, 3, "k5");
    run_frame(16'h0020, 1, "k5_ack");
    run_frames(16'h0420, 3, "k5_k10");
    check("roll_down", key_down, 1);
    check("roll_valid", key_valid, 0);
    run_frames(16'h0000, 3, "both_rel");
    check("both_rel_down", key_down, 0);

    // 6: reset in the middle of press debounce
    run_frame(16'h0008, 0, "rst_pre");
    held = 16'h0008;
    repeat (8) @(posedge clk);
    #1;
    do_reset();
    run_frames(16'h0008, 2, "rst_fresh");
    check("rst_fresh_none", key_valid, 0);
    run_frame(16'h0008, 0, "rst_emit");
    check("rst_emit_valid", key_valid, 1);
    check("rst_emit_code", key_code, 3);
    run_frames(16'h0000, 3, "rst_rel");

    // Random key activity with random acks
    cur = 0;
    for (int f = 0; f < 60; f++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        mask = '0;
      end else if (sel == 2) begin
        mask = '0;
        mask[$urandom_range(0, 15)] = 1'b1;
        mask[$urandom_range(0, 15)] = 1'b1;
      end else begin
        if (sel == 9) cur = $urandom_range(0, 15);
        mask = '0;
        mask[cur] = 1'b1;
      end
      run_frame(mask, $urandom_range(0, 2), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
